// File: rtl/exu_brupd_if.sv
// Branch-update bus between the ALU resolve stage, the update queue and the
// branch predictor.
//   upd_*    : resolved branch from the ALU stage (producer -> queue)
//   bp_*     : head entry presented to the predictor (queue -> predictor)
//   bp_ready : predictor accepts the head entry (predictor -> queue)
// modport slave  : the update queue (exu_brupd_ctl)
// modport master : the surrounding pipeline / predictor side
interface exu_brupd_if #(
  parameter int IDX_W = 8
);
  logic             upd_valid;
  logic             upd_misp;
  logic             upd_ataken;
  logic [1:0]       upd_hist;
  logic [IDX_W-1:0] upd_idx;
  logic [30:0]      upd_tgt;

  logic             bp_valid;
  logic             bp_ready;
  logic             bp_misp;
  logic             bp_ataken;
  logic [1:0]       bp_hist;
  logic [IDX_W-1:0] bp_idx;
  logic [30:0]      bp_tgt;

  modport slave (
    input  upd_valid, upd_misp, upd_ataken, upd_hist, upd_idx, upd_tgt,
    input  bp_ready,
    output bp_valid, bp_misp, bp_ataken, bp_hist, bp_idx, bp_tgt
  );

  modport master (
    output upd_valid, upd_misp, upd_ataken, upd_hist, upd_idx, upd_tgt,
    output bp_ready,
    input  bp_valid, bp_misp, bp_ataken, bp_hist, bp_idx, bp_tgt
  );
endinterface

// File: rtl/exu_brupd_ctl.sv
// Branch-predictor update queue. Resolved branches from the ALU stage are
// buffered in a DEPTH-entry FIFO and presented one at a time to the BHT/BTB
// update port with a valid/ready handshake.
//
// Ports:
//   clk       : single clock
//   rst       : synchronous, active-high reset
//   bus       : exu_brupd_if.slave (upd_* in, bp_* out, bp_ready in)
//   q_full    : all DEPTH entries occupied
//   drop_cnt  : updates lost to a full queue      (EXU_BRUPD_STATS_EN only)
//   misp_cnt  : mispredict updates stored         (EXU_BRUPD_STATS_EN only)
//
// Build option: define EXU_BRUPD_STATS_EN to add the saturating statistics
// counters drop_cnt/misp_cnt. Without it the ports and counters are absent.
//
// Entries become visible one cycle after they are written; there is no path
// from upd_* to bp_*. When the queue is full and cannot pop, a mispredicting
// update replaces the youngest entry instead of being lost, because mispredict
// training matters more than a plain counter update.
module exu_brupd_ctl #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  exu_brupd_if.slave  bus,
`ifdef EXU_BRUPD_STATS_EN
  output logic [15:0] drop_cnt,
  output logic [15:0] misp_cnt,
`endif
  output logic        q_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic             misp;
    logic             ataken;
    logic [1:0]       hist;
    logic [IDX_W-1:0] idx;
    logic [30:0]      tgt;
  } ent_t;

  ent_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_valid;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_ovr;
  logic             w_drop;
  logic [PTR_W-1:0] w_young_ptr;
  ent_t             w_din;
  ent_t             w_head;

  assign w_valid     = (r_count != '0);
  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_pop       = w_valid && bus.bp_ready;
  assign w_push      = bus.upd_valid && (!w_full || w_pop);
  assign w_young_ptr = r_wr_ptr - PTR_W'(1);

  // Overwrite only when the youngest slot is not the one being presented
  // (count > 1), so the head never changes under a stalled handshake.
  assign w_ovr  = bus.upd_valid && w_full && !w_pop && bus.upd_misp &&
                  (r_count > CNT_W'(1));
  assign w_drop = bus.upd_valid && w_full && !w_pop && !w_ovr;

  assign w_din.misp   = bus.upd_misp;
  assign w_din.ataken = bus.upd_ataken;
  assign w_din.hist   = bus.upd_hist;
  assign w_din.idx    = bus.upd_idx;
  assign w_din.tgt    = bus.upd_tgt;

  // Data fields read zero whenever nothing is presented.
  assign w_head = w_valid ? r_mem[r_rd_ptr] : '0;

  assign bus.bp_valid  = w_valid;
  assign bus.bp_misp   = w_head.misp;
  assign bus.bp_ataken = w_head.ataken;
  assign bus.bp_hist   = w_head.hist;
  assign bus.bp_idx    = w_head.idx;
  assign bus.bp_tgt    = w_head.tgt;
  assign q_full        = w_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_din;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_ovr) begin
        r_mem[w_young_ptr] <= w_din;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef EXU_BRUPD_STATS_EN
  logic [15:0] r_drop_cnt;
  logic [15:0] r_misp_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
      r_misp_cnt <= '0;
    end else begin
      if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
      if ((w_push || w_ovr) && bus.upd_misp && (r_misp_cnt != 16'hFFFF)) begin
        r_misp_cnt <= r_misp_cnt + 16'd1;
      end
    end
  end

  assign drop_cnt = r_drop_cnt;
  assign misp_cnt = r_misp_cnt;
`endif

endmodule

// File: doc/exu_brupd_ctl.md
EXU_BRUPD_CTL -- requirements
Module: exu_brupd_ctl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning update-queue entries; power of two, minimum 2.
REQ-002 SHALL have parameter IDX_W, default 8, meaning BHT index width.
REQ-003 SHALL have port clk  input  1  the single clock for all state.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port upd_valid  input  1  resolved branch from the ALU stage this cycle.
REQ-006 SHALL have port upd_misp  input  1  mispredict flag from the ALU predict packet.
REQ-007 SHALL have port upd_ataken  input  1  actual-taken flag.
REQ-008 SHALL have port upd_hist  input  2  new 2-bit counter value.
REQ-009 SHALL have port upd_idx  input  IDX_W  BHT index of the branch.
REQ-010 SHALL have port upd_tgt  input  31  resolved target [31:1].
REQ-011 SHALL have port bp_valid  output  1  head entry presented to the branch predictor.
REQ-012 SHALL have port bp_ready  input  1  predictor accepts the head entry.
REQ-013 SHALL have ports bp_misp, bp_ataken, bp_hist, bp_idx, bp_tgt  output  1/1/2/IDX_W/31  head entry fields.
REQ-014 SHALL have port q_full  output  1  all DEPTH entries occupied.

Function
REQ-015 SHALL enqueue {misp, ataken, hist, idx, tgt} when upd_valid=1 and the queue is not full, or when it is full and a pop occurs in the same cycle.
REQ-016 SHALL give the enqueued entry a minimum latency of one cycle: an entry written in cycle N can assert bp_valid no earlier than cycle N+1, with no combinational bypass from the upd_* inputs to the bp_* outputs.
REQ-017 SHALL pop the head entry when bp_valid=1 and bp_ready=1 in the same cycle.
REQ-018 SHALL hold the bp_* outputs stable while bp_valid=1 and bp_ready=0.
REQ-019 SHALL drive bp_valid=1 if and only if the occupancy count is non-zero.
REQ-020 SHALL keep read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH, and an occupancy count of log2(DEPTH)+1 bits.
REQ-021 SHALL drop an update arriving while full with no simultaneous pop, leaving queue contents and pointers unchanged.
REQ-022 SHALL apply the following exception to REQ-021 for a dropped update with upd_misp=1: overwrite the youngest entry with the incoming update, since mispredict training has priority.
REQ-023 SHALL apply the youngest-entry overwrite of REQ-022 only when the youngest entry is not the head, or when bp_valid=1 and bp_ready=0 hold in a cycle where the head is not also the youngest; otherwise the update is dropped.
REQ-024 SHALL leave the count unchanged on a simultaneous push and pop, and on an empty queue with a push and no entry to pop, only increment it.
REQ-025 SHALL make q_full combinational from the count (count==DEPTH).

Reset
REQ-026 SHALL, with rst=1 at a clk edge, clear the pointers, the count and all stored valid state, so that from the next cycle bp_valid=0, q_full=0 and all bp_* data fields read 0.
REQ-027 SHALL let reset asserted mid-operation discard all queued entries and ignore upd_valid in the reset cycle.
REQ-028 SHALL reset the stats counters of REQ-030 to 0.

Configuration
REQ-029 SHALL be controlled by the macro EXU_BRUPD_STATS_EN.
REQ-030 SHALL, when EXU_BRUPD_STATS_EN is defined, add outputs drop_cnt[15:0] and misp_cnt[15:0]:
- drop_cnt increments on each dropped update.
- misp_cnt increments on each enqueued or overwritten update with upd_misp=1.
- Both counters saturate at 16'hFFFF.
REQ-031 SHALL, when EXU_BRUPD_STATS_EN is undefined, omit these ports and counters, with all other behaviour identical.

Verification
REQ-032 SHALL cover a single update: reset, then upd_valid=1 with idx=8'h5A, tgt=31'h100 in cycle 1, bp_ready=1 -> bp_valid=1 with bp_idx=8'h5A in cycle 2, and bp_valid=0 in cycle 3.
REQ-033 SHALL cover backpressure: with bp_ready=0, push idx 1,2,3,4 -> q_full=1 after the fourth push, bp_idx stable at 1; then set bp_ready=1 -> entries pop in order 1,2,3,4 on consecutive cycles.
REQ-034 SHALL cover a drop while full: full queue, bp_ready=0, push idx=9 with misp=0 -> contents unchanged and drop_cnt=1 (stats build).
REQ-035 SHALL cover a mispredict overwrite: full queue {1,2,3,4}, bp_ready=0, push idx=9 with misp=1 -> popped order is 1,2,3,9 and misp_cnt=1.
REQ-036 SHALL cover a full-queue push-and-pop: full queue, bp_ready=1 with push idx=7 in the same cycle -> count stays 4 and 7 becomes the youngest entry, after wrap-around of the write pointer.
REQ-037 SHALL cover reset mid-operation: 3 entries queued, rst=1 for one cycle with upd_valid=1 -> the next cycle has bp_valid=0, q_full=0 and count 0.
